// File: rtl/arb_pkg.sv
// Shared types and default sizing for the round-robin arbiter.
package arb_pkg;

    localparam int N_DEF        = 4;
    localparam int HOLD_MAX_DEF = 8;

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: first set request after PTR, wrapping.
module rr_pick
    import arb_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int PW = ptr_w(N)
) (
    input  logic [N-1:0]  REQ,
    input  logic [PW-1:0] PTR,
    output logic [N-1:0]  PICK
);

    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        PICK  = '0;
        found = 1'b0;
        idx   = '0;
        // k runs 1..N so PTR itself is examined last
        for (int k = 1; k <= N; k++) begin
            idx = PW'((int'(PTR) + k) % N);
            if (!found && REQ[idx]) begin
                PICK[idx] = 1'b1;
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter4.sv
// Round-robin arbiter with a per-grant hold limit and timeout pulse.
module rr_arbiter4
    import arb_pkg::*;
#(
    parameter int N        = N_DEF,
    parameter int HOLD_MAX = HOLD_MAX_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] REQ,
    output logic [N-1:0] GNT,
    output logic         BUSY,
    output logic         ANY,
    output logic         TMO
);

    localparam int PW = ptr_w(N);
    localparam int CW = $clog2(HOLD_MAX + 1);
    localparam logic [CW-1:0] LAST = CW'(HOLD_MAX - 1);

    state_t        state;
    logic [PW-1:0] ptr;
    logic [CW-1:0] cnt;
    logic [N-1:0]  pick;
    logic [PW-1:0] pick_idx;

    rr_pick #(
        .N  (N),
        .PW (PW)
    ) u_pick (
        .REQ  (REQ),
        .PTR  (ptr),
        .PICK (pick)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (pick[i]) pick_idx = PW'(i);
        end
    end

    // ptr doubles as the index of the current grant while in GRANT
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            GNT   <= '0;
            BUSY  <= 1'b0;
            ANY   <= 1'b0;
            TMO   <= 1'b0;
            cnt   <= '0;
            ptr   <= PW'(N - 1);
        end else begin
            ANY <= |REQ;
            TMO <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (|REQ) begin
                        state <= GRANT;
                        GNT   <= pick;
                        BUSY  <= 1'b1;
                        ptr   <= pick_idx;
                        cnt   <= '0;
                    end else begin
                        GNT  <= '0;
                        BUSY <= 1'b0;
                    end
                end
                GRANT: begin
                    if (!REQ[ptr]) begin
                        state <= IDLE;
                        GNT   <= '0;
                        BUSY  <= 1'b0;
                    end else if (cnt == LAST) begin
                        state <= IDLE;
                        GNT   <= '0;
                        BUSY  <= 1'b0;
                        TMO   <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    GNT   <= '0;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arbiter4.sv
// Scoreboard bench for rr_arbiter4: directed vectors plus random invariants.
module tb_rr_arbiter4;

    logic       clk;
    logic       rst;
    logic [3:0] REQ;
    logic [3:0] GNT;
    logic       BUSY;
    logic       ANY;
    logic       TMO;

    typedef struct {
        logic [3:0] gnt;
        logic       busy;
        logic       any;
        logic       tmo;
        string      tag;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    rr_arbiter4 #(
        .N        (4),
        .HOLD_MAX (8)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .REQ  (REQ),
        .GNT  (GNT),
        .BUSY (BUSY),
        .ANY  (ANY),
        .TMO  (TMO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // One stimulus cycle; expectation is for the outputs after the next edge
    task automatic cyc(input string tag, input logic r, input logic [3:0] rq,
                       input logic [3:0] g, input logic t);
        exp_t e;
        @(negedge clk);
        rst = r;
        REQ = rq;
        e.gnt  = g;
        e.busy = |g;
        e.any  = r ? 1'b0 : |rq;
        e.tmo  = t;
        e.tag  = tag;
        q.push_back(e);
    endtask

    task automatic do_reset(input string tag);
        cyc(tag, 1'b1, 4'b0000, 4'b0000, 1'b0);
        cyc(tag, 1'b1, 4'b0000, 4'b0000, 1'b0);
    endtask

    // Scoreboard monitor
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk({e.tag, ".gnt"},  32'(GNT),  32'(e.gnt));
                chk({e.tag, ".busy"}, 32'(BUSY), 32'(e.busy));
                chk({e.tag, ".any"},  32'(ANY),  32'(e.any));
                chk({e.tag, ".tmo"},  32'(TMO),  32'(e.tmo));
            end
        end
    end

    // Invariants checked every cycle
    initial begin
        logic [3:0] req_s;
        logic       rst_s;
        forever begin
            @(posedge clk);
            req_s = REQ;
            rst_s = rst;
            #1;
            chk("inv.onehot0", 32'($onehot0(GNT)), 32'd1);
            chk("inv.busy", 32'(BUSY), 32'(|GNT));
            chk("inv.any", 32'(ANY), 32'(rst_s ? 1'b0 : |req_s));
        end
    end

    initial begin
        int wait_cnt;
        rst = 1'b1;
        REQ = 4'b0000;

        // Basic grant and release
        do_reset("a.rst");
        cyc("a1", 0, 4'b0001, 4'b0001, 0);
        cyc("a2", 0, 4'b0001, 4'b0001, 0);
        cyc("a3", 0, 4'b0001, 4'b0001, 0);
        cyc("a4", 0, 4'b0000, 4'b0000, 0);
        cyc("a5", 0, 4'b0000, 4'b0000, 0);

        // Round-robin rotation with one idle cycle between grants
        do_reset("b.rst");
        cyc("b1",  0, 4'b1111, 4'b0001, 0);
        cyc("b2",  0, 4'b1110, 4'b0000, 0);
        cyc("b3",  0, 4'b1111, 4'b0010, 0);
        cyc("b4",  0, 4'b1101, 4'b0000, 0);
        cyc("b5",  0, 4'b1111, 4'b0100, 0);
        cyc("b6",  0, 4'b1011, 4'b0000, 0);
        cyc("b7",  0, 4'b1111, 4'b1000, 0);
        cyc("b8",  0, 4'b0111, 4'b0000, 0);
        cyc("b9",  0, 4'b1111, 4'b0001, 0);
        cyc("b10", 0, 4'b1110, 4'b0000, 0);

        // Hold limit: 8 cycles granted, one TMO idle cycle, regrant
        do_reset("c.rst");
        for (int i = 1; i <= 20; i++) begin
            if ((i - 1) % 9 == 8)
                cyc("c.tmo", 0, 4'b0100, 4'b0000, 1);
            else
                cyc("c.hold", 0, 4'b0100, 4'b0100, 0);
        end
        cyc("c.rel", 0, 4'b0000, 4'b0000, 0);

        // Timed-out requester loses priority
        do_reset("d.rst");
        for (int i = 1; i <= 8; i++)
            cyc("d.hold", 0, 4'b0101, 4'b0001, 0);
        cyc("d.tmo", 0, 4'b0101, 4'b0000, 1);
        cyc("d.next", 0, 4'b0101, 4'b0100, 0);
        cyc("d.rel", 0, 4'b0000, 4'b0000, 0);

        // Reset during a grant
        do_reset("e.rst");
        cyc("e1", 0, 4'b0010, 4'b0010, 0);
        cyc("e2", 1, 4'b0010, 4'b0000, 0);
        cyc("e3", 0, 4'b1001, 4'b0001, 0);
        cyc("e4", 0, 4'b0000, 4'b0000, 0);

        // New requests during a grant are ignored
        do_reset("f.rst");
        cyc("f1", 0, 4'b0100, 4'b0100, 0);
        cyc("f2", 0, 4'b0101, 4'b0100, 0);
        cyc("f3", 0, 4'b1111, 4'b0100, 0);
        cyc("f4", 0, 4'b1011, 4'b0000, 0);
        cyc("f5", 0, 4'b1011, 4'b1000, 0);
        cyc("f6", 0, 4'b0000, 4'b0000, 0);

        // Release coinciding with the hold limit gives no TMO
        do_reset("g.rst");
        for (int i = 1; i <= 8; i++)
            cyc("g.hold", 0, 4'b0001, 4'b0001, 0);
        cyc("g.rel", 0, 4'b0000, 4'b0000, 0);
        cyc("g.idle", 0, 4'b0000, 4'b0000, 0);

        // Let the scoreboard drain before random traffic
        wait_cnt = 0;
        while (q.size() > 0 && wait_cnt < 20) begin
            @(posedge clk);
            wait_cnt++;
        end
        #2;
        chk("sb.drain", 32'(q.size()), 32'd0);

        // Random traffic, checked by the invariant process
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 99) == 0);
            REQ = 4'($urandom_range(0, 15));
        end
        @(negedge clk);
        rst = 1'b0;
        REQ = 4'b0000;
        repeat (2) @(posedge clk);
        #2;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
